// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the load/store unit (master)
// and the data memory responder (slave).
interface data_mem_responder_if #(
    parameter int addr_data_width = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr;
    logic [addr_data_width-1:0] req_addr;
    logic [1:0]                 req_size;
    logic                       req_unsigned;
    logic [addr_data_width-1:0] req_wdata;
    logic                       resp_valid;
    logic [addr_data_width-1:0] resp_rdata;
    logic                       resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: masked stores, latency-programmable loads
// with byte/half extraction. Optional misalignment trap: DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int addr_data_width = 32,
    parameter int mem_depth_words = 256,
    parameter int read_latency    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int W       = addr_data_width;
    localparam int IDX_W   = $clog2(mem_depth_words);
    localparam int CNT_W   = (read_latency > 2) ? $clog2(read_latency - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((read_latency > 1) ? (read_latency - 2) : 0);
    localparam bit   LOAD_ONE_CYCLE = (read_latency == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data so every enabled lane sees its bytes.
    function automatic logic [31:0] f_store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction
`endif

    logic [31:0]      r_mem [mem_depth_words];
    state_t           r_state;
    logic             r_ready;
    logic             r_resp_valid;
    logic [W-1:0]     r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic             r_misalign;

    logic             w_accept;
    logic [IDX_W-1:0] w_req_idx;
    logic [1:0]       w_req_lane;
    logic             w_req_mis;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_lanes;
    logic [31:0]      w_req_word;
    logic [31:0]      w_cap_word;
    logic             w_unused_addr;

    assign w_accept      = bus.req_valid & r_ready;
    assign w_req_idx     = bus.req_addr[IDX_W+1:2];
    assign w_req_lane    = bus.req_addr[1:0];
    assign w_be          = f_byte_en(bus.req_size, w_req_lane);
    assign w_wdata_lanes = f_store_lanes(bus.req_size, bus.req_wdata);
    assign w_req_word    = r_mem[w_req_idx];
    assign w_cap_word    = r_mem[r_idx];
    assign w_unused_addr = &{1'b0, bus.req_addr[W-1:IDX_W+2]};

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign w_req_mis = f_misaligned(bus.req_size, w_req_lane);
`else
    assign w_req_mis = 1'b0;
`endif

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // Masked store at the accepting edge; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_wr && !w_req_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_req_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM; the load word is sampled on the edge that enters RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= {W{1'b0}};
            r_err        <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_lane       <= 2'b00;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    if (w_accept) begin
                        r_ready    <= 1'b0;
                        r_idx      <= w_req_idx;
                        r_lane     <= w_req_lane;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_misalign <= w_req_mis;
                        if (bus.req_wr) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= w_req_mis;
                        end else if (LOAD_ONE_CYCLE) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= w_req_mis;
                            r_rdata      <= w_req_mis ? 32'h0000_0000
                                          : f_extract(w_req_word, w_req_lane, bus.req_size, bus.req_unsigned);
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_err        <= r_misalign;
                        r_rdata      <= r_misalign ? 32'h0000_0000
                                      : f_extract(w_cap_word, r_lane, r_size, r_unsigned);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_ready      <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (read_latency = 2, 256 words).
module tb_data_mem_responder;
    localparam int DEPTH = 256;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        rb;
    logic        va;
    logic        ra;

    data_mem_responder_if #(.addr_data_width(32)) bus ();

    data_mem_responder #(
        .addr_data_width(32),
        .mem_depth_words(DEPTH),
        .read_latency(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE and watch the response with a bounded wait.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int o_lat, output logic [31:0] o_rd, output logic o_err,
                          output logic o_rdy_busy, output logic o_vld_after, output logic o_rdy_after);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_wr       = wr;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        o_lat = -1;
        o_rd = 32'h0;
        o_err = 1'b0;
        o_rdy_busy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            o_rdy_busy = o_rdy_busy | bus.req_ready;
            if (bus.resp_valid) begin
                o_lat = c;
                o_rd  = bus.resp_rdata;
                o_err = bus.resp_err;
                break;
            end
        end
        @(negedge clk);
        o_vld_after = bus.resp_valid;
        o_rdy_after = bus.req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else n_pass++;
        n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 00000000", bus.resp_rdata); else n_pass++;
        n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.resp_err); else n_pass++;
    endtask

    task automatic test_word();
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, er, rb, va, ra);
        n_total++; if (lat !== 1) $display("FAIL store_latency got %0d want 1", lat); else n_pass++;
        n_total++; if (va !== 1'b0 || ra !== 1'b1) $display("FAIL store_after got valid=%b ready=%b want 0/1", va, ra); else n_pass++;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (lat !== 2) $display("FAIL load_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_word got %h want deadbeef", rd); else n_pass++;
        n_total++; if (rb !== 1'b0) $display("FAIL load_ready_busy got %b want 0", rb); else n_pass++;
        n_total++; if (va !== 1'b0 || ra !== 1'b1) $display("FAIL load_after got valid=%b ready=%b want 0/1", va, ra); else n_pass++;
        n_total++; if (bus.resp_rdata !== 32'hDEADBEEF) $display("FAIL rdata_hold_idle got %h want deadbeef", bus.resp_rdata); else n_pass++;
    endtask

    task automatic test_byte();
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'hFFFFFF80, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL store_keeps_rdata got %h want deadbeef", rd); else n_pass++;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h80000000) $display("FAIL byte_word got %h want 80000000", rd); else n_pass++;
        do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb got %h want ffffff80", rd); else n_pass++;
        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h00000080) $display("FAIL lbu got %h want 00000080", rd); else n_pass++;
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h1234565A, lat, rd, er, rb, va, ra);
        do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h0000005A) $display("FAIL lbu_lane1 got %h want 0000005a", rd); else n_pass++;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h80005A00) $display("FAIL byte_lanes_word got %h want 80005a00", rd); else n_pass++;
    endtask

    task automatic test_half();
        do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, lat, rd, er, rb, va, ra);
        do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'hABCD8001, lat, rd, er, rb, va, ra);
        do_req(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hFFFF8001) $display("FAIL lh got %h want ffff8001", rd); else n_pass++;
        do_req(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h00008001) $display("FAIL lhu got %h want 00008001", rd); else n_pass++;
        do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h80013344) $display("FAIL half_word got %h want 80013344", rd); else n_pass++;
        do_req(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h00003344) $display("FAIL lh_low got %h want 00003344", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_wr       = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        #2;
        n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", bus.resp_valid); else n_pass++;
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", bus.req_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen = seen | bus.resp_valid;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL midreset_no_resp got %b want 0", seen); else n_pass++;
        n_total++; if (bus.req_ready !== 1'b1) $display("FAIL midreset_idle got %b want 1", bus.req_ready); else n_pass++;
        do_req(1'b1, DEPTH * 4 + 32'h4, 2'b10, 1'b0, 32'h12345678, lat, rd, er, rb, va, ra);
        do_req(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h12345678) $display("FAIL wrap got %h want 12345678", rd); else n_pass++;
    endtask

    task automatic test_misalign();
        do_req(1'b1, 32'h30, 2'b10, 1'b0, 32'hA5A5A5A5, lat, rd, er, rb, va, ra);
        n_total++; if (er !== 1'b0) $display("FAIL aligned_store_err got %b want 0", er); else n_pass++;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        do_req(1'b1, 32'h31, 2'b10, 1'b0, 32'hFFFFFFFF, lat, rd, er, rb, va, ra);
        n_total++; if (er !== 1'b1 || lat !== 1) $display("FAIL mis_store got err=%b lat=%0d want 1/1", er, lat); else n_pass++;
        do_req(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) $display("FAIL mis_nowrite got %h err=%b want a5a5a5a5/0", rd, er); else n_pass++;
        do_req(1'b0, 32'h33, 2'b01, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 2) $display("FAIL mis_load got %h err=%b lat=%0d want 00000000/1/2", rd, er, lat); else n_pass++;
`else
        do_req(1'b0, 32'h33, 2'b01, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hFFFFA5A5 || er !== 1'b0) $display("FAIL odd_half got %h err=%b want ffffa5a5/0", rd, er); else n_pass++;
        do_req(1'b0, 32'h31, 2'b10, 1'b0, 32'h0, lat, rd, er, rb, va, ra);
        n_total++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) $display("FAIL odd_word got %h err=%b want a5a5a5a5/0", rd, er); else n_pass++;
`endif
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reset_mid_wait();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the datapath's load/store interface. It accepts one request at a time from the load/store unit over a valid/ready handshake.
- Stores are byte-lane masked. Loads return after a programmable latency, with byte/half extraction and sign/zero extension.
- It replaces the combinational data_memory once the datapath moves to a stall-on-memory scheme.

Parameters:
- addr_data_width, 32: address and data width in bits.
- mem_depth_words, 256: number of 32-bit words in the array. Must be a power of 2.
- read_latency, 2: cycles from load acceptance to response. Must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  addr_data_width  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_unsigned  input  1  zero-extend the load result (lbu/lhu).
- req_wdata  input  addr_data_width  store data, right-aligned.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  addr_data_width  load result.
- resp_err  output  1  misaligned-access flag. Constant 0 without the optional feature.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - The memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - A transfer occurs on a rising edge with req_valid & req_ready. wr, addr, size, unsigned and wdata are captured at that edge.
  - Store: the masked memory write happens at the accepting edge. Next state is RESP.
  - Load with read_latency = 1: next state is RESP.
  - Load with read_latency > 1: next state is WAIT, counter = read_latency - 2.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle. When counter = 0, next state is RESP.
- RESP:
  - req_ready = 0, resp_valid = 1 for exactly one cycle. Next state is IDLE.
  - The response cannot be back-pressured.
- Latency:
  - Store accepted at edge N: resp_valid is high in the cycle after edge N.
  - Load accepted at edge N: resp_valid is high in cycle N + read_latency.
  - Maximum throughput is one request per 2 cycles (store) or per read_latency + 1 cycles (load).
- Addressing:
  - Word index = req_addr[log2(mem_depth_words)+1 : 2]. Higher address bits are ignored, so addresses wrap modulo the array size.
  - Lane = req_addr[1:0].
- Store masking:
  - Byte: writes lane addr[1:0] with wdata[7:0].
  - Half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. addr[0] is ignored.
  - Word: writes all lanes. addr[1:0] are ignored.
  - Unwritten lanes are unchanged.
- Load extraction:
  - Selects the same lanes as the store masking, right-aligns them and extends to addr_data_width.
  - Sign-extends unless req_unsigned = 1. req_unsigned is ignored for word loads.
- Store responses: resp_rdata keeps its previous value.
- resp_rdata holding: updated only on a load response, held otherwise.
- Reads sample the array in the cycle the response is formed (RESP entry). No other writer can exist, since only one request is in flight.
- req_valid in WAIT or RESP is ignored; the requester must hold it until req_ready.
- Reset mid-operation (WAIT/RESP): the pending response is dropped and no resp_valid is issued. A store already accepted remains written.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word/11 access with addr[1:0] != 0, is misaligned.
  - A misaligned store performs no array write.
  - Timing is unchanged. In RESP, resp_err = 1 and resp_rdata = 0 for a misaligned load; a misaligned store leaves resp_rdata unchanged.
  - resp_err = 0 for aligned accesses.
- Undefined: the low address bits are ignored as described in Behaviour, and resp_err is tied to 0.

Test Plan:
- Reset, then hold reset high for 3 idle cycles -> req_ready = 1, resp_valid = 0, resp_rdata = 0x00000000.
- Store word 0xDEADBEEF @0x10, then load word @0x10 (read_latency = 2) -> store resp_valid the cycle after acceptance; load resp_valid exactly 2 cycles after acceptance with resp_rdata = 0xDEADBEEF. req_ready is low until the cycle after RESP.
- Store byte 0x80 @0x13 over 0x00000000, then:
  - load word @0x10 -> 0x80000000;
  - load byte @0x13 -> 0xFFFFFF80;
  - load byte unsigned @0x13 -> 0x00000080.
- Store half 0x8001 @0x22, then load half @0x22 -> 0xFFFF8001; load half unsigned -> 0x00008001; word @0x20 -> upper 16 bits = 0x8001, lower 16 bits unchanged.
- Assert reset while in WAIT during a load -> no resp_valid; returns to IDLE. Store word 0x12345678 @(mem_depth_words*4 + 0x4), then load @0x4 -> 0x12345678 (wrap-around).
- With DATA_MEM_MISALIGN_TRAP_EN, store word 0xFFFFFFFF @0x31 -> resp_err = 1, no write; load word @0x30 returns the old value. Load half @0x33 -> resp_err = 1, resp_rdata = 0.
